// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the host-link UART blocks (receiver and transmitter).
//   state_t     : receiver frame state
//   DATA_BITS   : data bits per character
//   calc_div()  : clk cycles per oversample tick, rounded to nearest
//   majority3() : 2-of-3 vote used for mid-bit sampling
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   // round(clk_freq / (baud * oversample)), evaluated at elaboration time.
   function automatic int calc_div(input longint clk_freq,
                                   input longint baud,
                                   input longint oversample);
      longint den;
      den = baud * oversample;
      return int'((clk_freq + den / 2) / den);
   endfunction

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-clk tick every DIV clocks. Shared by the
// receiver and transmitter.
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   restart in  forces the divider back to 0 so ticks align to a frame edge
//   tick    out one-clk pulse every DIV clocks (first one DIV clks after restart)
// -----------------------------------------------------------------------------
module uart_baud_tick #(
   parameter int DIV = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// -----------------------------------------------------------------------------
// uart_rx_frame
// UART receiver for the host link. Oversamples rx, majority-votes each bit at
// mid-bit, deframes 8N1 (8E1 when UART_RX_PARITY_EN is defined) and strobes
// each clean byte to the downstream IO controller.
// Configuration macro: UART_RX_PARITY_EN (adds even-parity bit and parity_err).
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   rx         in   asynchronous serial line, idles high
//   rx_data    out  last good byte, held until the next good byte
//   rx_done    out  one-clk strobe, rx_data valid in the same cycle
//   frame_err  out  one-clk strobe, stop bit sampled low
//   parity_err out  one-clk strobe, parity mismatch (0 without parity)
//   busy       out  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
   localparam int TW  = $clog2(OVERSAMPLE);
   localparam int M   = OVERSAMPLE / 2 - 1;

   localparam logic [TW-1:0] T_LO   = TW'(M - 1);
   localparam logic [TW-1:0] T_MID  = TW'(M);
   localparam logic [TW-1:0] T_HI   = TW'(M + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   // ---------------------------------------------------------------------------
   // Synchronizer and start-edge qualification
   // ---------------------------------------------------------------------------
   logic [1:0] sync_q;
   logic [1:0] fill_q;    // marks when sync_q holds real pin samples, not reset values
   logic       rxs_hi_q;  // rxs was genuinely seen high on the previous clk
   logic       rxs;

   assign rxs = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= 2'b11;
         fill_q   <= 2'b00;
         rxs_hi_q <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], rx};
         fill_q   <= {fill_q[0], 1'b1};
         // Only a high level observed from the pin itself arms edge detection,
         // so a line held low through reset cannot look like a start edge.
         rxs_hi_q <= fill_q[1] & rxs;
      end
   end

   // ---------------------------------------------------------------------------
   // Tick generation
   // ---------------------------------------------------------------------------
   state_t state_q;
   logic   tick;
   logic   start_edge;

   assign start_edge = (state_q == ST_IDLE) && rxs_hi_q && !rxs;

   uart_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .clk     (clk),
      .reset   (reset),
      .restart (start_edge),
      .tick    (tick)
   );

   // ---------------------------------------------------------------------------
   // Mid-bit vote
   // ---------------------------------------------------------------------------
   logic [TW-1:0] tcnt_q;
   logic [TW-1:0] tcnt_d;
   logic [1:0]    smp_q;
   logic          vote_now;
   logic          vote_d;

   // NOTE: every signal written in always_comb gets a value on every path,
   // otherwise synthesis infers a latch.
   always_comb begin
      tcnt_d   = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);
      vote_now = tick && (tcnt_q == T_HI);
      // Third sample is the live line at tick M+1; the first two were stored.
      vote_d   = majority3(smp_q[1], smp_q[0], rxs);
   end

   // ---------------------------------------------------------------------------
   // Frame FSM with registered outputs
   // ---------------------------------------------------------------------------
   logic [2:0]           bit_idx_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 done_q;
   logic                 ferr_q;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q;
   logic                 par_bad_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the shift register and output byte are reset as well, so a
         // discarded partial frame can never leak into rx_data.
         state_q   <= ST_IDLE;
         tcnt_q    <= '0;
         smp_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
`endif

         if (tick && state_q != ST_IDLE) begin
            tcnt_q <= tcnt_d;
            if (tcnt_q == T_LO || tcnt_q == T_MID) begin
               smp_q <= {smp_q[0], rxs};
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (start_edge) begin
                  state_q   <= ST_START;
                  tcnt_q    <= '0;
                  bit_idx_q <= '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_q <= 1'b0;
`endif
               end
            end

            ST_START: begin
               // A start bit that is not low at mid-bit was a glitch.
               if (vote_now) begin
                  bit_idx_q <= '0;
                  state_q   <= vote_d ? ST_IDLE : ST_DATA;
               end
            end

            ST_DATA: begin
               if (vote_now) begin
                  shreg_q   <= {vote_d, shreg_q[DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= ST_PARITY;
`else
                     state_q <= ST_STOP;
`endif
                  end
               end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               // Even parity: data bits plus parity bit XOR to zero.
               if (vote_now) begin
                  par_bad_q <= vote_d ^ (^shreg_q);
                  state_q   <= ST_STOP;
               end
            end
`endif

            ST_STOP: begin
               if (vote_now) begin
                  if (!vote_d) begin
                     // Framing error wins over a parity error in the same frame.
                     ferr_q  <= 1'b1;
                     state_q <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
                  end else if (par_bad_q) begin
                     perr_q  <= 1'b1;
                     state_q <= ST_IDLE;
`endif
                  end else begin
                     data_q  <= shreg_q;
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
            end

            ST_BREAK: begin
               // Hold off until the line recovers so a stuck-low line cannot
               // retrigger the receiver.
               if (rxs) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rx_data   = data_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_frame
// Self-checking bench for uart_rx_frame at default parameters (432 clk/bit).
// Expected bytes go into a scoreboard queue when a frame is sent; a monitor
// pops and compares them on every rx_done. Scenario tasks check strobe counts,
// busy and rx_data directly.
// -----------------------------------------------------------------------------
module tb_uart_rx_frame;

   localparam int BIT_CLKS = 432;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_good = 8'h00;

   uart_rx_frame dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .rx_data    (rx_data),
      .rx_done    (rx_done),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: sampled on the falling edge, away from DUT updates.
   always @(negedge clk) begin
      if (!reset) begin
         if (rx_done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard: unexpected rx_done with rx_data=%02h", rx_data);
            end else begin
               logic [7:0] exp_b;
               exp_b = exp_q.pop_front();
               if (rx_data !== exp_b) begin
                  errors++;
                  $display("FAIL scoreboard: rx_data=%02h expected %02h", rx_data, exp_b);
               end
            end
         end
         if (frame_err)  ferr_cnt++;
         if (parity_err) perr_cnt++;
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      wait_clks(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`else
      if (par_flip) rx = 1'b1;
`endif
      drive_bit(stop_bit);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rx    = 1'b1;
      wait_clks(4);
      checks += 5;
      if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %02h want 00", rx_data); end
      if (rx_done !== 1'b0)   begin errors++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      wait_clks(BIT_CLKS);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_good_byte();
      int d0, f0, p0;
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b0);
      last_good = 8'hA5;
      checks += 5;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL good_done_count: got %0d want 1", done_cnt - d0); end
      if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL good_frame_err: got %0d want 0", ferr_cnt - f0); end
      if (perr_cnt - p0 !== 0) begin errors++; $display("FAIL good_parity_err: got %0d want 0", perr_cnt - p0); end
      if (busy !== 1'b0)       begin errors++; $display("FAIL good_busy: got %b want 0", busy); end
      if (rx_data !== 8'hA5)   begin errors++; $display("FAIL good_rx_data: got %02h want a5", rx_data); end
   endtask

   task automatic test_framing_error();
      int d0, f0;
      d0 = done_cnt; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 1'b0);
      rx = 1'b0;
      wait_clks(2000);
      checks += 4;
      if (ferr_cnt - f0 !== 1)   begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
      if (done_cnt - d0 !== 0)   begin errors++; $display("FAIL ferr_done_count: got %0d want 0", done_cnt - d0); end
      if (rx_data !== last_good) begin errors++; $display("FAIL ferr_rx_data: got %02h want %02h", rx_data, last_good); end
      if (busy !== 1'b1)         begin errors++; $display("FAIL ferr_break_busy: got %b want 1", busy); end
      rx = 1'b1;
      wait_clks(10);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL ferr_release_busy: got %b want 0", busy); end
      wait_clks(BIT_CLKS);
   endtask

   task automatic test_glitch();
      int d0, f0, p0;
      d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      rx = 1'b0;
      wait_clks(100);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL glitch_start_busy: got %b want 1", busy); end
      rx = 1'b1;
      wait_clks(300);
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL glitch_reject_busy: got %b want 0", busy); end
      if ((done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0) !== 0) begin
         errors++;
         $display("FAIL glitch_strobes: got %0d strobes want 0",
                  (done_cnt - d0) + (ferr_cnt - f0) + (perr_cnt - p0));
      end
      wait_clks(BIT_CLKS);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1, 1'b0);
      last_good = 8'h5A;
      checks += 2;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL glitch_follow_count: got %0d want 1", done_cnt - d0); end
      if (rx_data !== 8'h5A)   begin errors++; $display("FAIL glitch_follow_data: got %02h want 5a", rx_data); end
   endtask

   task automatic test_back_to_back();
      int d0;
      logic [7:0] bytes [3];
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
      d0 = done_cnt;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(bytes[i]);
         send_frame(bytes[i], 1'b1, 1'b0);
      end
      last_good = 8'h81;
      checks += 3;
      if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", done_cnt - d0); end
      if (exp_q.size() !== 0)  begin errors++; $display("FAIL b2b_queue_left: got %0d want 0", exp_q.size()); end
      if (rx_data !== 8'h81)   begin errors++; $display("FAIL b2b_last_data: got %02h want 81", rx_data); end
   endtask

   task automatic test_reset_mid_frame();
      int d0, f0;
      logic [7:0] partial;
      partial = 8'h77;
      d0 = done_cnt; f0 = ferr_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(partial[i]);
      rx    = 1'b0;
      reset = 1'b1;
      wait_clks(1);
      checks += 4;
      if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_rx_data: got %02h want 00", rx_data); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
      if ({rx_done, frame_err, parity_err} !== 3'b000) begin
         errors++;
         $display("FAIL midrst_strobes: got %b want 000", {rx_done, frame_err, parity_err});
      end
      if (done_cnt - d0 !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt - d0); end
      reset = 1'b0;
      wait_clks(50);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_low_line_busy: got %b want 0", busy); end
      rx = 1'b1;
      wait_clks(BIT_CLKS);
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0);
      last_good = 8'h12;
      checks += 3;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL midrst_next_count: got %0d want 1", done_cnt - d0); end
      if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_next_ferr: got %0d want 0", ferr_cnt - f0); end
      if (rx_data !== 8'h12)   begin errors++; $display("FAIL midrst_next_data: got %02h want 12", rx_data); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int d0, p0;
      d0 = done_cnt; p0 = perr_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      checks += 3;
      if (perr_cnt - p0 !== 1)   begin errors++; $display("FAIL parity_bad_count: got %0d want 1", perr_cnt - p0); end
      if (done_cnt - d0 !== 0)   begin errors++; $display("FAIL parity_bad_done: got %0d want 0", done_cnt - d0); end
      if (rx_data !== last_good) begin errors++; $display("FAIL parity_bad_data: got %02h want %02h", rx_data, last_good); end
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b0);
      last_good = 8'h07;
      checks += 3;
      if (done_cnt - d0 !== 1) begin errors++; $display("FAIL parity_good_done: got %0d want 1", done_cnt - d0); end
      if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_good_perr: got %0d want 1", perr_cnt - p0); end
      if (rx_data !== 8'h07)   begin errors++; $display("FAIL parity_good_data: got %02h want 07", rx_data); end
   endtask
`endif

   initial begin
      test_reset();
      test_good_byte();
      test_framing_error();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      wait_clks(20);
      checks++;
      if (exp_q.size() !== 0) begin errors++; $display("FAIL final_queue: got %0d pending want 0", exp_q.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
